// File: rtl/iddr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : iddr_pkg
// Description : Shared types and constants for the IDDR bit-pair deserializer
//               and its word-alignment training FSM.
// Revision    : 1.0 - initial release
// ============================================================================
package iddr_pkg;

    // Legal range of the parallel word width.
    localparam int c_WIDTH_MIN = 4;
    localparam int c_WIDTH_MAX = 16;

    // Training FSM states.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_HOLD   = 2'd1,
        S_CHECK  = 2'd2,
        S_LOCKED = 2'd3
    } align_state_t;

endpackage : iddr_pkg
`default_nettype wire

// File: rtl/iddr_align_fsm.sv
`default_nettype none
// ============================================================================
// Module      : iddr_align_fsm
// Description : Training FSM. Watches the deserialized words, requests single
//               bit slips until TRAIN_PATTERN is seen MATCH_COUNT times in a
//               row, and flags a sticky error after WIDTH fruitless slips.
// Revision    : 1.0 - initial release
// ============================================================================
module iddr_align_fsm
    import iddr_pkg::*;
#(
    parameter int               WIDTH         = 8,
    parameter logic [WIDTH-1:0] TRAIN_PATTERN = '0,
    parameter int               MATCH_COUNT   = 4,
    parameter int               HOLDOFF       = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_align_en,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_dout,
    output logic             o_slip_req,
    output logic             o_locked,
    output logic             o_align_err
);

    localparam int c_SW = $clog2(WIDTH + 1);

    align_state_t    r_state;
    align_state_t    w_state_nxt;
    logic [2:0]      r_hold_cnt;
    logic [2:0]      w_hold_nxt;
    logic [3:0]      r_match_cnt;
    logic [3:0]      w_match_nxt;
    logic [3:0]      w_match_inc;
    logic [c_SW-1:0] r_slip_cnt;
    logic [c_SW-1:0] w_slip_cnt_nxt;
    logic [c_SW-1:0] w_slip_inc;
    logic            r_err;
    logic            w_err_nxt;
    logic            r_locked;
    logic            w_slip_req;

    assign w_match_inc = r_match_cnt + 4'd1;
    assign w_slip_inc  = r_slip_cnt + c_SW'(1);

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_hold_cnt  <= '0;
            r_match_cnt <= '0;
            r_slip_cnt  <= '0;
            r_err       <= 1'b0;
            r_locked    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_hold_cnt  <= w_hold_nxt;
            r_match_cnt <= w_match_nxt;
            r_slip_cnt  <= w_slip_cnt_nxt;
            r_err       <= w_err_nxt;
            r_locked    <= (w_state_nxt == S_LOCKED);
        end
    end

    // Next-state logic; dropping ALIGN_EN overrides everything and clears state.
    always_comb begin
        w_state_nxt    = r_state;
        w_hold_nxt     = r_hold_cnt;
        w_match_nxt    = r_match_cnt;
        w_slip_cnt_nxt = r_slip_cnt;
        w_err_nxt      = r_err;
        w_slip_req     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_hold_nxt  = '0;
                w_match_nxt = '0;
                w_state_nxt = S_HOLD;
            end
            S_HOLD: begin
                if (i_valid) begin
                    if (r_hold_cnt == 3'(HOLDOFF - 1)) begin
                        w_hold_nxt  = '0;
                        w_state_nxt = S_CHECK;
                    end else begin
                        w_hold_nxt = r_hold_cnt + 3'd1;
                    end
                end
            end
            S_CHECK: begin
                if (i_valid) begin
                    if (i_dout == TRAIN_PATTERN) begin
                        if (w_match_inc == 4'(MATCH_COUNT)) begin
                            w_match_nxt = '0;
                            w_state_nxt = S_LOCKED;
                        end else begin
                            w_match_nxt = w_match_inc;
                        end
                    end else begin
                        w_match_nxt = '0;
                        w_hold_nxt  = '0;
                        w_slip_req  = 1'b1;
                        w_state_nxt = S_HOLD;
                        if (w_slip_inc == c_SW'(WIDTH)) begin
                            w_slip_cnt_nxt = '0;
                            w_err_nxt      = 1'b1;
                        end else begin
                            w_slip_cnt_nxt = w_slip_inc;
                        end
                    end
                end
            end
            S_LOCKED: begin
                w_state_nxt = S_LOCKED;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (!i_align_en) begin
            w_state_nxt    = S_IDLE;
            w_hold_nxt     = '0;
            w_match_nxt    = '0;
            w_slip_cnt_nxt = '0;
            w_err_nxt      = 1'b0;
            w_slip_req     = 1'b0;
        end
    end

    assign o_slip_req  = w_slip_req;
    assign o_locked    = r_locked;
    assign o_align_err = r_err;

endmodule : iddr_align_fsm
`default_nettype wire

// File: rtl/iddr_deser.sv
`default_nettype none
// ============================================================================
// Module      : iddr_deser
// Description : Packs IDDR Q1/Q2 bit pairs into WIDTH-bit words with a
//               one-cycle VALID strobe; word boundary adjustable by single-bit
//               slips from a manual pulse or the training FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module iddr_deser
    import iddr_pkg::*;
#(
    parameter int               WIDTH         = 8,
    parameter logic [WIDTH-1:0] TRAIN_PATTERN = WIDTH'(8'hA5),
    parameter int               MATCH_COUNT   = 4,
    parameter int               HOLDOFF       = 2
) (
    input  logic             C,
    input  logic             R_N,
    input  logic             CE,
    input  logic             D1,
    input  logic             D2,
    input  logic             BITSLIP,
    input  logic             ALIGN_EN,
    output logic [WIDTH-1:0] DOUT,
    output logic             VALID,
    output logic             LOCKED,
    output logic             ALIGN_ERR
);

    generate
        if (WIDTH < c_WIDTH_MIN || WIDTH > c_WIDTH_MAX) begin : g_bad_width
            $error("iddr_deser: WIDTH outside legal range");
        end
    endgenerate

    localparam int              c_CW = $clog2(WIDTH + 2);
    localparam logic [c_CW-1:0] c_W  = c_CW'(WIDTH);
    localparam logic [c_CW-1:0] c_W1 = c_CW'(WIDTH + 1);

    // Between words at most WIDTH-1 bits are pending, so WIDTH bits of storage
    // suffice; the post-append view below is WIDTH+1 bits wide.
    logic [WIDTH-1:0] r_sr;
    logic [c_CW-1:0]  r_cnt;
    logic             r_slip_pend;
    logic [WIDTH-1:0] r_dout;
    logic             r_valid;

    logic             w_fsm_slip;
    logic             w_req;
    logic             w_slip;
    logic             w_drop_d1;
    logic [c_CW-1:0]  w_cnt_slip;
    logic [c_CW-1:0]  w_cnt_app;
    logic [WIDTH:0]   w_sr_app;
    logic             w_emit;
    logic [WIDTH-1:0] w_word;

    // Manual slips are ignored while training owns the alignment.
    assign w_req  = (BITSLIP & ~ALIGN_EN) | w_fsm_slip;
    assign w_slip = r_slip_pend | w_req;

    // Slip-then-append: a slip drops the oldest pending bit, or D1 when empty.
    always_comb begin
        w_drop_d1  = w_slip && (r_cnt == '0);
        w_cnt_slip = r_cnt;
        if (w_slip && !w_drop_d1) begin
            w_cnt_slip = r_cnt - c_CW'(1);
        end
        if (w_drop_d1) begin
            w_sr_app  = {r_sr[WIDTH-1:0], D2};
            w_cnt_app = w_cnt_slip + c_CW'(1);
        end else begin
            w_sr_app  = {r_sr[WIDTH-2:0], D1, D2};
            w_cnt_app = w_cnt_slip + c_CW'(2);
        end
        w_emit = (w_cnt_app >= c_W);
        w_word = (w_cnt_app == c_W1) ? w_sr_app[WIDTH:1] : w_sr_app[WIDTH-1:0];
    end

    // Pending-bit store, word output and slip-request latch.
    always_ff @(posedge C or negedge R_N) begin
        if (!R_N) begin
            r_sr        <= '0;
            r_cnt       <= '0;
            r_slip_pend <= 1'b0;
            r_dout      <= '0;
            r_valid     <= 1'b0;
        end else if (CE) begin
            r_sr        <= w_sr_app[WIDTH-1:0];
            r_cnt       <= w_emit ? (w_cnt_app - c_W) : w_cnt_app;
            r_slip_pend <= 1'b0;
            r_valid     <= w_emit;
            if (w_emit) begin
                r_dout <= w_word;
            end
        end else begin
            r_slip_pend <= w_slip;
            r_valid     <= 1'b0;
        end
    end

    iddr_align_fsm #(
        .WIDTH         (WIDTH),
        .TRAIN_PATTERN (TRAIN_PATTERN),
        .MATCH_COUNT   (MATCH_COUNT),
        .HOLDOFF       (HOLDOFF)
    ) u_align_fsm (
        .clk         (C),
        .rst_n       (R_N),
        .i_align_en  (ALIGN_EN),
        .i_valid     (r_valid),
        .i_dout      (r_dout),
        .o_slip_req  (w_fsm_slip),
        .o_locked    (LOCKED),
        .o_align_err (ALIGN_ERR)
    );

    assign DOUT  = r_dout;
    assign VALID = r_valid;

endmodule : iddr_deser
`default_nettype wire

// File: tb/tb_iddr_deser.sv
`default_nettype none
// ============================================================================
// Module      : tb_iddr_deser
// Description : Self-checking bench for iddr_deser (WIDTH=8). A bit-queue
//               reference model pushes expected words to a scoreboard as
//               stimulus is driven; training tests observe slips and lock.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iddr_deser;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         ce;
    logic         d1;
    logic         d2;
    logic         bitslip;
    logic         align_en;
    logic [W-1:0] dout;
    logic         valid;
    logic         locked;
    logic         align_err;

    always #5 clk = ~clk;

    iddr_deser #(
        .WIDTH         (W),
        .TRAIN_PATTERN (8'hA5),
        .MATCH_COUNT   (4),
        .HOLDOFF       (2)
    ) dut (
        .C         (clk),
        .R_N       (rst_n),
        .CE        (ce),
        .D1        (d1),
        .D2        (d2),
        .BITSLIP   (bitslip),
        .ALIGN_EN  (align_en),
        .DOUT      (dout),
        .VALID     (valid),
        .LOCKED    (locked),
        .ALIGN_ERR (align_err)
    );

    int           n_total = 0;
    int           n_bad   = 0;
    bit           mq[$];
    logic [W-1:0] exp_q[$];
    bit           m_pend;
    bit           sb_en;
    logic [7:0]   pat;
    int           bidx;
    logic [W-1:0] last_dout;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic next_bit(output bit b);
        b    = pat[7-bidx];
        bidx = (bidx + 1) % 8;
    endtask

    // Reference model: pending bits held as a queue, oldest at the front.
    task automatic model_step(input bit c, input bit a, input bit b, input bit req);
        bit           slip;
        bit           drop;
        logic [W-1:0] w;
        if (!c) begin
            m_pend = m_pend | req;
            return;
        end
        slip   = m_pend | req;
        m_pend = 1'b0;
        drop   = 1'b0;
        if (slip) begin
            if (mq.size() > 0) void'(mq.pop_front());
            else drop = 1'b1;
        end
        if (!drop) mq.push_back(a);
        mq.push_back(b);
        if (mq.size() >= W) begin
            w = '0;
            for (int i = 0; i < W; i++) w = {w[W-2:0], mq.pop_front()};
            exp_q.push_back(w);
        end
    endtask

    // One clock: drive at negedge, sample 1 time unit after posedge.
    task automatic cyc(input bit c, input bit bs);
        bit a;
        bit b;
        @(negedge clk);
        if (c) begin
            next_bit(a);
            next_bit(b);
        end else begin
            a = 1'($urandom_range(0, 1));
            b = 1'($urandom_range(0, 1));
        end
        ce      = c;
        d1      = a;
        d2      = b;
        bitslip = bs;
        if (sb_en) model_step(c, a, b, bs & !align_en);
        @(posedge clk);
        #1;
        if (valid) last_dout = dout;
        if (sb_en) begin
            chk("valid", {31'd0, valid}, {31'd0, exp_q.size() != 0});
            if (exp_q.size() != 0) begin
                if (valid) chk("dout", {24'd0, dout}, {24'd0, exp_q[0]});
                void'(exp_q.pop_front());
            end
        end
    endtask

    task automatic do_reset(input bit aen, input logic [7:0] p);
        @(negedge clk);
        rst_n    = 1'b0;
        ce       = 1'b0;
        bitslip  = 1'b0;
        align_en = aen;
        mq.delete();
        exp_q.delete();
        m_pend = 1'b0;
        pat    = p;
        bidx   = 0;
        #1;
        chk("rst_dout",   {24'd0, dout},    32'd0);
        chk("rst_valid",  {31'd0, valid},   32'd0);
        chk("rst_locked", {31'd0, locked},  32'd0);
        chk("rst_err",    {31'd0, align_err}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nslip;
        int n_a5;
        int nw;
        bit have_prev;
        logic [W-1:0] prev;

        rst_n = 1'b1; ce = 1'b0; d1 = 1'b0; d2 = 1'b0;
        bitslip = 1'b0; align_en = 1'b0; m_pend = 1'b0; sb_en = 1'b1;

        // Continuous CE: first word on the 4th edge, then every 4th cycle.
        do_reset(1'b0, 8'hA5);
        repeat (12) cyc(1'b1, 1'b0);
        chk("t1_word", {24'd0, last_dout}, 32'hA5);

        // Alternating CE: no word during CE=0 cycles.
        do_reset(1'b0, 8'hA5);
        for (int i = 0; i < 16; i++) cyc((i % 2) == 0, 1'b0);
        chk("t2_word", {24'd0, last_dout}, 32'hA5);

        // Manual slips: one -> 4B, three more -> 5A.
        do_reset(1'b0, 8'hA5);
        repeat (9) cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b1);
        repeat (11) cyc(1'b1, 1'b0);
        chk("t3_rot1", {24'd0, last_dout}, 32'h4B);
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0);
        repeat (9) cyc(1'b1, 1'b0);
        align_en = 1'b1;
        cyc(1'b1, 1'b1);
        align_en = 1'b0;
        cyc(1'b1, 1'b1);
        repeat (9) cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b1);
        repeat (12) cyc(1'b1, 1'b0);
        chk("t3_rot4", {24'd0, last_dout}, 32'h5A);

        // Training on A5 stream with 3-bit offset (words start as B4).
        sb_en = 1'b0;
        do_reset(1'b1, 8'hB4);
        nslip = 0; n_a5 = 0; have_prev = 1'b0; prev = '0;
        for (int i = 0; i < 600; i++) begin
            cyc(1'b1, 1'b0);
            if (valid) begin
                if (have_prev && dout != prev) nslip++;
                if (dout == 8'hA5) n_a5++;
                prev = dout;
                have_prev = 1'b1;
            end
            if (locked) break;
        end
        chk("t4_locked", {31'd0, locked}, 32'd1);
        chk("t4_slips", nslip, 32'd3);
        chk("t4_a5_words", n_a5, 32'd6);
        chk("t4_err", {31'd0, align_err}, 32'd0);
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 1'b0);
            if (valid) chk("t4_locked_word", {24'd0, dout}, 32'hA5);
        end
        chk("t4_still_locked", {31'd0, locked}, 32'd1);
        align_en = 1'b0;
        repeat (2) cyc(1'b1, 1'b0);
        chk("t4_unlock", {31'd0, locked}, 32'd0);

        // Training on all-zero stream: error after 8 slips (24 words).
        do_reset(1'b1, 8'h00);
        nw = 0;
        for (int i = 0; i < 1000; i++) begin
            cyc(1'b1, 1'b0);
            if (align_err) break;
            if (valid) nw++;
        end
        chk("t5_err", {31'd0, align_err}, 32'd1);
        chk("t5_words", nw, 32'd24);
        chk("t5_locked", {31'd0, locked}, 32'd0);
        repeat (20) cyc(1'b1, 1'b0);
        chk("t5_err_sticky", {31'd0, align_err}, 32'd1);
        align_en = 1'b0;
        repeat (2) cyc(1'b1, 1'b0);
        chk("t5_err_clear", {31'd0, align_err}, 32'd0);

        // Reset mid-word (cnt=4): outputs clear, fresh 4 CE cycles to a word.
        sb_en = 1'b1;
        do_reset(1'b0, 8'hA5);
        repeat (6) cyc(1'b1, 1'b0);
        chk("t6_pre", {24'd0, dout}, 32'hA5);
        do_reset(1'b0, 8'hA5);
        repeat (3) cyc(1'b1, 1'b0);
        chk("t6_novalid", {31'd0, valid}, 32'd0);
        cyc(1'b1, 1'b0);
        chk("t6_valid", {31'd0, valid}, 32'd1);
        chk("t6_word", {24'd0, dout}, 32'hA5);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_iddr_deser
`default_nettype wire
